// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the 3x3 convolution stream controller
// Contents:
//   KERNEL_DIM         window edge length; a window is interior once row/col reach KERNEL_DIM-1
//   DEFAULT_WORD_SIZE  default pixel width
//   ctrl_state_t       controller FSM states {IDLE, RUN, FLUSH}
//   tag_t              per-advance tag {valid, last} carried alongside the datapath
package conv_pkg;

    localparam int KERNEL_DIM        = 3;
    localparam int DEFAULT_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/conv_tag_pipe.sv
// rtl/conv_tag_pipe.sv - tag shift register tracking the convolution datapath latency
// Ports:
//   clk   in   clock
//   rst   in   synchronous, active-high reset
//   en    in   shift one stage (datapath advance)
//   clr   in   drop all tags in flight (wins over en)
//   din   in   tag of the pixel being shifted into the datapath
//   dout  out  tag aligned with the datapath result of the current advance
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  tag_t din,
    output tag_t dout
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_stream_ctrl.sv
// rtl/conv_stream_ctrl.sv - frame sequencer for the 3x3 convolution datapath
// Optional feature macro: CONV_STREAM_CTRL_PERF_EN (adds the stall_cnt port and counter).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         raster pixel stream handshake, in_sof marks pixel (0,0)
//   in_pixel                  raster-order pixel
//   conv_en, conv_pix         datapath advance strobe and the pixel shifted in (0 while flushing)
//   conv_result               datapath output, CONV_LAT advances behind conv_pix
//   out_valid/out_ready       interior-window result handshake, out_pixel data, out_eof last of frame
//   frame_done                pulse the cycle after the EOF result handshakes
//   frame_err                 pulse after a SOF arrived mid-frame
//   stall_cnt (macro only)    saturating count of stalled RUN/FLUSH cycles
module conv_stream_ctrl
    import conv_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int IMG_W     = 540,
    parameter int IMG_H     = 540,
    parameter int CONV_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [WORD_SIZE-1:0] in_pixel,
    output logic                 conv_en,
    output logic [WORD_SIZE-1:0] conv_pix,
    input  logic [WORD_SIZE-1:0] conv_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_pixel,
    output logic                 out_eof,
    output logic                 frame_done,
    output logic                 frame_err
`ifdef CONV_STREAM_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(CONV_LAT + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN    = CW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] ROW_MIN    = RW'(KERNEL_DIM - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(CONV_LAT - 1);

    ctrl_state_t   state, state_nxt;
    logic [RW-1:0] row, eff_row;
    logic [CW-1:0] col, eff_col;
    logic [FW-1:0] flush_cnt;
    logic          stall, accept, sof_acc, restart, pix_adv, last_pix;
    tag_t          tag_in, tag_out;

    assign stall   = out_valid & ~out_ready;
    assign accept  = in_valid & in_ready;
    assign sof_acc = accept & in_sof;
    assign restart = sof_acc & (state == RUN);
    assign pix_adv = conv_en & (state != FLUSH);

    // A SOF pixel is always position (0,0), whatever the counters held.
    assign eff_row  = sof_acc ? '0 : row;
    assign eff_col  = sof_acc ? '0 : col;
    assign last_pix = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

    assign tag_in.valid = pix_adv && (eff_row >= ROW_MIN) && (eff_col >= COL_MIN);
    assign tag_in.last  = pix_adv && last_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sof_acc) state_nxt = RUN;
            RUN:     if (pix_adv && last_pix) state_nxt = FLUSH;
            FLUSH:   if (conv_en && flush_cnt == FLUSH_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        conv_en  = 1'b0;
        conv_pix = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    // Pixels before a SOF are consumed but never reach the datapath.
                    in_ready = ~stall;
                    conv_en  = in_valid & ~stall & in_sof;
                    conv_pix = conv_en ? in_pixel : '0;
                end
                RUN: begin
                    in_ready = ~stall;
                    conv_en  = in_valid & ~stall;
                    conv_pix = conv_en ? in_pixel : '0;
                end
                FLUSH: begin
                    conv_en = ~stall;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            flush_cnt <= '0;
        end else begin
            if (pix_adv) begin
                if (last_pix) begin
                    row <= '0;
                    col <= '0;
                end else if (eff_col == COL_LAST) begin
                    row <= eff_row + 1'b1;
                    col <= '0;
                end else begin
                    row <= eff_row;
                    col <= eff_col + 1'b1;
                end
            end
            if (conv_en && state == FLUSH) begin
                flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
            end
        end
    end

    conv_tag_pipe #(
        .DEPTH (CONV_LAT)
    ) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .en   (conv_en),
        .clr  (restart),
        .din  (tag_in),
        .dout (tag_out)
    );

    // The last tag stage lines up with conv_result during an advance, so the
    // result is captured only on advances; stalls block advances entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_eof;
            frame_err  <= restart;
            if (restart) begin
                out_valid <= 1'b0;
                out_eof   <= 1'b0;
            end else if (conv_en && tag_out.valid) begin
                out_valid <= 1'b1;
                out_pixel <= conv_result;
                out_eof   <= tag_out.last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end

`ifdef CONV_STREAM_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || sof_acc) begin
            stall_cnt <= '0;
        end else if (stall && state != IDLE && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // No stall instrumentation in this build.
`endif

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb/tb_conv_stream_ctrl.sv - directed self-checking bench for conv_stream_ctrl (5x4 frame, latency 4)
module tb_conv_stream_ctrl;

    localparam int W = 5;
    localparam int H = 4;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [7:0] in_pixel;
    logic       conv_en;
    logic [7:0] conv_pix;
    logic [7:0] conv_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_eof;
    logic       frame_done;
    logic       frame_err;
`ifdef CONV_STREAM_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    conv_stream_ctrl #(
        .WORD_SIZE (8),
        .IMG_W     (W),
        .IMG_H     (H),
        .CONV_LAT  (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_pixel    (in_pixel),
        .conv_en     (conv_en),
        .conv_pix    (conv_pix),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
`ifdef CONV_STREAM_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Datapath model: 3x3 window sum (clamped to 255) of the window whose
    // bottom-right pixel is the one shifted in, delivered L advances later.
    logic [7:0] hist [12] = '{default: 8'd0};
    logic [7:0] rp   [L]  = '{default: 8'd0};
    int         wsum;
    assign conv_result = rp[L-1];

    always @(posedge clk) begin
        if (conv_en) begin
            wsum = conv_pix + hist[0] + hist[1] + hist[4] + hist[5] + hist[6]
                 + hist[9] + hist[10] + hist[11];
            hist[0] <= conv_pix;
            for (int i = 1; i < 12; i++) hist[i] <= hist[i-1];
            rp[0] <= (wsum > 255) ? 8'd255 : wsum[7:0];
            for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
        end
    end

    // Observation, sampled on the falling edge.
    logic [7:0] res_q [$];
    logic       eof_q [$];
    int         cyc = 0;
    int         en_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         acc_cyc = -1;
    int         rise_cyc = -1;
    bit         chk_stable = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_pix = 8'd0;
    logic       prev_eof = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_stable && prev_stall) begin
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_pixel", 32'(out_pixel), 32'(prev_pix));
            check("stall_hold_eof", 32'(out_eof), 32'(prev_eof));
        end
        if (out_valid && out_ready) begin
            res_q.push_back(out_pixel);
            eof_q.push_back(out_eof);
        end
        if (conv_en) en_cnt++;
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (conv_en && conv_pix == 8'd12 && acc_cyc < 0) acc_cyc = cyc;
        if (out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_stall = out_valid & ~out_ready;
        prev_valid = out_valid;
        prev_pix   = out_pixel;
        prev_eof   = out_eof;
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic send_pix(input logic [7:0] v, input logic sof, input bit gap);
        int n;
        if (gap && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pixel = v;
        in_sof   = sof;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) send_pix(8'(i), i == 0, gap);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_frame_done_once"}, 32'(done_cnt - d0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [7:0] exp_pix [6] = '{8'd54, 8'd63, 8'd72, 8'd99, 8'd108, 8'd117};
        check({tag, "_count"}, 32'(res_q.size() - base), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < res_q.size()) begin
                check($sformatf("%s_pix%0d", tag, k), 32'(res_q[base+k]), 32'(exp_pix[k]));
                check($sformatf("%s_eof%0d", tag, k), 32'(eof_q[base+k]), 32'(k == 5));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_conv_en"}, 32'(conv_en), 32'd0);
        check({tag, "_conv_pix"}, 32'(conv_pix), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_pixel"}, 32'(out_pixel), 32'd0);
        check({tag, "_out_eof"}, 32'(out_eof), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, e0, en0, eofs;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Reset state
        check_idle_outputs("reset");
`ifdef CONV_STREAM_CTRL_PERF_EN
        check("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: back-to-back ramp, no backpressure
        base = res_q.size(); d0 = done_cnt;
        send_range(0, 19, 1'b0);
        wait_done("c1", d0);
        check_frame("c1", base);
        check("c1_first_rise_latency", 32'(rise_cyc - acc_cyc), 32'd5);

        // 2: out_ready toggling every cycle
        base = res_q.size(); d0 = done_cnt;
        chk_stable = 1'b1;
        fork
            send_range(0, 19, 1'b0);
            begin
                repeat (120) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        chk_stable = 1'b0;
        wait_done("c2", d0);
        check_frame("c2", base);

        // 3: ~50% input duty
        base = res_q.size(); d0 = done_cnt; en0 = en_cnt;
        send_range(0, 19, 1'b1);
        wait_done("c3", d0);
        check_frame("c3", base);
        check("c3_conv_en_count", 32'(en_cnt - en0), 32'd24);

        // 4: SOF mid-frame at pixel 7, then again at pixel 13 with an interior tag in flight
        base = res_q.size(); d0 = done_cnt; e0 = err_cnt;
        send_range(0, 6, 1'b0);
        send_range(0, 12, 1'b0);
        send_range(0, 19, 1'b0);
        wait_done("c4", d0);
        check("c4_frame_err_pulses", 32'(err_cnt - e0), 32'd2);
        check_frame("c4", base);

        // 5: reset while flushing
        base = res_q.size(); d0 = done_cnt;
        send_range(0, 19, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("c5_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("c5_idle_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);
        eofs = 0;
        for (int k = base; k < eof_q.size(); k++) eofs += int'(eof_q[k]);
        check("c5_no_eof_after_rst", 32'(eofs), 32'd0);
        check("c5_no_frame_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk); #1;
        base = res_q.size(); d0 = done_cnt;
        send_range(0, 19, 1'b0);
        wait_done("c5_next", d0);
        check_frame("c5_next", base);

`ifdef CONV_STREAM_CTRL_PERF_EN
        // 6: ten stalled cycles in RUN
        base = res_q.size(); d0 = done_cnt;
        send_range(0, 16, 1'b0);
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("c6_stall_cnt", stall_cnt, 32'd10);
        out_ready = 1'b1;
        send_range(17, 19, 1'b0);
        wait_done("c6", d0);
        check_frame("c6", base);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
